stream_block_sorter: RTL

Parametrised stream sorter for the merge-sort front end. It collects up to `BLK` words from a valid/ready input stream and emits each block sorted, descending or ascending, on a valid/ready output stream. A short final block, closed by `in_last`, is also emitted sorted. It replaces the fixed two-word pair sorter with full backpressure and a selectable sort direction, and its output feeds the first merge stage.

---
 rtl/stream_block_sorter.sv | 118 +++++++++++
 1 files changed

// File: rtl/stream_block_sorter.sv
// rtl/stream_block_sorter.sv - collects blocks of up to BLK words and emits each block sorted
module stream_block_sorter #(
  parameter int DATA_W = 32,
  parameter int BLK    = 4,
  parameter int CNT_W  = $clog2(BLK + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              desc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_blk_end,
  input  logic              out_ready
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] arr    [BLK];
  logic [DATA_W-1:0] arr_nx [BLK];
  logic [CNT_W-1:0]  cnt, len, rd;
  logic              dir, blk_last;
  logic [BLK-1:0]    ins;
  logic              dir_eff, in_fire, out_fire, rd_end, blk_close, drain_done;

  assign in_fire    = (state == FILL) && in_valid && in_ready;
  assign out_fire   = (state == DRAIN) && out_valid && out_ready;
  assign rd_end     = ((rd + CNT_W'(1)) == len);
  assign blk_close  = in_fire && (in_last || (cnt == CNT_W'(BLK - 1)));
  assign drain_done = out_fire && rd_end;
  // The first word of a block uses the live direction input; later words use the latched one.
  assign dir_eff    = (cnt == '0) ? desc : dir;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: fill until the block closes, drain until its last word is taken.
  always_comb begin
    state_nx = state;
    case (state)
      FILL:  if (blk_close)  state_nx = DRAIN;
      DRAIN: if (drain_done) state_nx = FILL;
    endcase
  end

  // Parallel insertion: ins[i] marks slots at or above the insert position, which is a
  // contiguous upper range because arr is kept sorted. Strict compares keep ties stable.
  always_comb begin
    ins = '0;
    for (int i = 0; i < BLK; i++) begin
      ins[i] = (CNT_W'(i) == cnt) ||
               ((CNT_W'(i) < cnt) && (dir_eff ? (in_data > arr[i]) : (in_data < arr[i])));
    end
    arr_nx[0] = ins[0] ? in_data : arr[0];
    for (int i = 1; i < BLK; i++) begin
      arr_nx[i] = !ins[i] ? arr[i] : (ins[i-1] ? arr[i-1] : in_data);
    end
  end

  // Block storage, counters and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK; i++) arr[i] <= '0;
      cnt       <= '0;
      len       <= '0;
      rd        <= '0;
      dir       <= 1'b0;
      blk_last  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == FILL) begin
        in_ready <= !blk_close;
        if (in_fire) begin
          for (int i = 0; i < BLK; i++) arr[i] <= arr_nx[i];
          cnt <= cnt + CNT_W'(1);
          if (cnt == '0) dir <= desc;
        end
        if (blk_close) begin
          len       <= cnt + CNT_W'(1);
          blk_last  <= in_last;
          rd        <= '0;
          out_valid <= 1'b1;
        end
      end else begin
        in_ready <= drain_done;
        if (out_fire) rd <= rd + CNT_W'(1);
        if (drain_done) begin
          cnt       <= '0;
          rd        <= '0;
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Output word and block markers, decoded only from registered state.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < BLK; i++) begin
      if (out_valid && (CNT_W'(i) == rd)) out_data = arr[i];
    end
    out_blk_end = out_valid && rd_end;
    out_last    = out_blk_end && blk_last;
  end

endmodule
